// File: rtl/video_pkg.sv
`default_nettype none
// =====================================================================
// video_pkg : shared timing defaults, widths and scanout FSM states
// Rev 1.0
// =====================================================================
package video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int PIX_W  = 24;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/video_scanout_if.sv
`default_nettype none
// =====================================================================
// video_scanout_if : framebuffer read port plus pixel/sync stream
// Rev 1.0
// =====================================================================
interface video_scanout_if;
  import video_pkg::*;

  logic              en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [PIX_W-1:0]  pix_rgb;
  logic              pix_valid;
  logic              hsync;
  logic              vsync;
  logic              frame_start;
  logic              busy;

  modport master (
    input  en, rd_data,
    output rd_addr, rd_en, pix_rgb, pix_valid, hsync, vsync, frame_start, busy
  );

  modport slave (
    output en, rd_data,
    input  rd_addr, rd_en, pix_rgb, pix_valid, hsync, vsync, frame_start, busy
  );

endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// =====================================================================
// video_timing_gen : raster counters and active/sync/frame flags
// Rev 1.0
// =====================================================================
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic frame_start_o,
  output logic frame_end_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare count of headroom so the sync-end bound fits with a zero back porch
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!run_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign active_o      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hsync_o       = (hcnt_q >= H_SS) && (hcnt_q < H_SE);
  assign vsync_o       = (vcnt_q >= V_SS) && (vcnt_q < V_SE);
  assign frame_start_o = (hcnt_q == '0) && (vcnt_q == '0);
  assign frame_end_o   = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

endmodule
`default_nettype wire

// File: rtl/video_scanout.sv
`default_nettype none
// =====================================================================
// video_scanout : raster-order framebuffer reader driving a display
// Rev 1.0
// =====================================================================
module video_scanout
  import video_pkg::*;
#(
  parameter int                H_ACTIVE = DEF_H_ACTIVE,
  parameter int                H_FP     = DEF_H_FP,
  parameter int                H_SYNC   = DEF_H_SYNC,
  parameter int                H_BP     = DEF_H_BP,
  parameter int                V_ACTIVE = DEF_V_ACTIVE,
  parameter int                V_FP     = DEF_V_FP,
  parameter int                V_SYNC   = DEF_V_SYNC,
  parameter int                V_BP     = DEF_V_BP,
  parameter logic [ADDR_W-1:0] FB_BASE  = 32'h0000_0000,
  parameter logic              SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  video_scanout_if.master vif
);

  scan_state_e state_q, state_d;
  logic        run;
  logic        t_active, t_hsync, t_vsync, t_fstart, t_fend;
  logic        s0_act, s0_hs, s0_vs, s0_fs;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_en_q;
  logic              s1_hs_q, s1_vs_q, s1_fs_q;
  logic              s2_act_q, s2_hs_q, s2_vs_q, s2_fs_q;
  logic [PIX_W-1:0]  pix_rgb_q;
  logic              pix_valid_q, hsync_q, vsync_q, frame_start_q;
  logic              unused_rd_hi;

  assign run = (state_q != ST_IDLE);

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .run_i         (run),
    .active_o      (t_active),
    .hsync_o       (t_hsync),
    .vsync_o       (t_vsync),
    .frame_start_o (t_fstart),
    .frame_end_o   (t_fend)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (vif.en) state_d = ST_RUN;
      // A stop request on the very last cycle has nothing left to finish
      ST_RUN:   if (!vif.en) state_d = t_fend ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (vif.en)      state_d = ST_RUN;
        else if (t_fend) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Idle counters sit at (0,0), so every raw flag is qualified by run
  assign s0_act = run & t_active;
  assign s0_hs  = run & t_hsync;
  assign s0_vs  = run & t_vsync;
  assign s0_fs  = run & t_fstart;

  always_comb begin
    ptr_d = ptr_q;
    if (!run || t_fend) ptr_d = FB_BASE;
    else if (t_active)  ptr_d = ptr_q + ADDR_W'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= FB_BASE;
      rd_addr_q     <= FB_BASE;
      rd_en_q       <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      s1_fs_q       <= 1'b0;
      s2_act_q      <= 1'b0;
      s2_hs_q       <= 1'b0;
      s2_vs_q       <= 1'b0;
      s2_fs_q       <= 1'b0;
      pix_rgb_q     <= '0;
      pix_valid_q   <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      rd_en_q       <= s0_act;
      if (s0_act) rd_addr_q <= ptr_q;
      s1_hs_q       <= s0_hs;
      s1_vs_q       <= s0_vs;
      s1_fs_q       <= s0_fs;
      s2_act_q      <= rd_en_q;
      s2_hs_q       <= s1_hs_q;
      s2_vs_q       <= s1_vs_q;
      s2_fs_q       <= s1_fs_q;
      pix_valid_q   <= s2_act_q;
      pix_rgb_q     <= s2_act_q ? vif.rd_data[PIX_W-1:0] : '0;
      hsync_q       <= s2_hs_q ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= s2_vs_q ? SYNC_POL : ~SYNC_POL;
      frame_start_q <= s2_fs_q;
    end
  end

  assign unused_rd_hi = ^vif.rd_data[DATA_W-1:PIX_W];

  assign vif.rd_addr     = rd_addr_q;
  assign vif.rd_en       = rd_en_q;
  assign vif.pix_rgb     = pix_rgb_q;
  assign vif.pix_valid   = pix_valid_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.frame_start = frame_start_q;
  assign vif.busy        = run;

endmodule
`default_nettype wire

// File: tb/tb_video_scanout.sv
`default_nettype none
// =====================================================================
// tb_video_scanout : directed checks of scanout timing, drain and reset
// Rev 1.0
// =====================================================================
module tb_video_scanout;

  typedef struct {
    int          cyc;
    logic        busy;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        pv;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   npv;
  int   nfs;
  int   nidle;
  vec_t tbl[$];

  video_scanout_if bus ();

  video_scanout #(
    .H_ACTIVE (4),
    .H_FP     (1),
    .H_SYNC   (2),
    .H_BP     (1),
    .V_ACTIVE (3),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .FB_BASE  (32'h0000_1000),
    .SYNC_POL (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns its own address; garbage when not read so blanking is visible
  always @(posedge clk) bus.rd_data <= bus.rd_en ? bus.rd_addr : 32'hDEAD_BEEF;

  function automatic vec_t mk(int cyc, logic busy, logic rd_en, logic [31:0] addr,
                              logic pv, logic [23:0] rgb, logic hs, logic vs, logic fs);
    vec_t v;
    v.cyc = cyc; v.busy = busy; v.rd_en = rd_en; v.rd_addr = addr;
    v.pv = pv; v.rgb = rgb; v.hs = hs; v.vs = vs; v.fs = fs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, " busy"}, 32'(bus.busy), 32'(v.busy));
    chk({tag, " rd_en"}, 32'(bus.rd_en), 32'(v.rd_en));
    if (v.rd_en) chk({tag, " rd_addr"}, bus.rd_addr, v.rd_addr);
    chk({tag, " pix_valid"}, 32'(bus.pix_valid), 32'(v.pv));
    chk({tag, " pix_rgb"}, 32'(bus.pix_rgb), 32'(v.rgb));
    chk({tag, " hsync"}, 32'(bus.hsync), 32'(v.hs));
    chk({tag, " vsync"}, 32'(bus.vsync), 32'(v.vs));
    chk({tag, " frame_start"}, 32'(bus.frame_start), 32'(v.fs));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;

    // k = cycles after the edge that samples en=1 in IDLE; outputs sampled at negedge
    tbl.push_back(mk( 0, 1, 0, 32'h0,    0, 24'h0,      1, 1, 0));
    tbl.push_back(mk( 1, 1, 1, 32'h1000, 0, 24'h0,      1, 1, 0));
    tbl.push_back(mk( 2, 1, 1, 32'h1004, 0, 24'h0,      1, 1, 0));
    tbl.push_back(mk( 3, 1, 1, 32'h1008, 1, 24'h001000, 1, 1, 1));
    tbl.push_back(mk( 4, 1, 1, 32'h100C, 1, 24'h001004, 1, 1, 0));
    tbl.push_back(mk( 5, 1, 0, 32'h0,    1, 24'h001008, 1, 1, 0));
    tbl.push_back(mk( 7, 1, 0, 32'h0,    0, 24'h0,      1, 1, 0));
    tbl.push_back(mk( 8, 1, 0, 32'h0,    0, 24'h0,      0, 1, 0));
    tbl.push_back(mk( 9, 1, 1, 32'h1010, 0, 24'h0,      0, 1, 0));
    tbl.push_back(mk(10, 1, 1, 32'h1014, 0, 24'h0,      1, 1, 0));
    tbl.push_back(mk(11, 1, 1, 32'h1018, 1, 24'h001010, 1, 1, 0));
    tbl.push_back(mk(22, 1, 0, 32'h0,    1, 24'h00102C, 1, 1, 0));
    tbl.push_back(mk(23, 1, 0, 32'h0,    0, 24'h0,      1, 1, 0));
    tbl.push_back(mk(34, 1, 0, 32'h0,    0, 24'h0,      1, 1, 0));
    tbl.push_back(mk(35, 1, 0, 32'h0,    0, 24'h0,      1, 0, 0));
    tbl.push_back(mk(40, 1, 0, 32'h0,    0, 24'h0,      0, 0, 0));
    tbl.push_back(mk(43, 1, 0, 32'h0,    0, 24'h0,      1, 1, 0));
    tbl.push_back(mk(49, 1, 1, 32'h1000, 0, 24'h0,      0, 1, 0));
    tbl.push_back(mk(51, 1, 1, 32'h1008, 1, 24'h001000, 1, 1, 1));
    tbl.push_back(mk(52, 1, 1, 32'h100C, 1, 24'h001004, 1, 1, 0));

    repeat (3) @(negedge clk);
    chk_vec("reset", mk(0, 0, 0, 32'h0, 0, 24'h0, 1, 1, 0));
    chk("reset rd_addr", bus.rd_addr, 32'h1000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle busy", 32'(bus.busy), 32'h0);

    // Continuous run: first frame and start of the second
    bus.en = 1'b1;
    npv = 0; nfs = 0;
    for (int k = 0; k <= 52; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 50) begin
        npv += int'(bus.pix_valid);
        nfs += int'(bus.frame_start);
      end
      foreach (tbl[i]) if (tbl[i].cyc == k) chk_vec($sformatf("run k=%0d", k), tbl[i]);
    end
    chk("valid per frame", 32'(npv), 32'd12);
    chk("frame_start per frame", 32'(nfs), 32'd1);

    // Drain: en dropped mid line 1 of frame 2, frame finishes, then idle
    npv = 0; nfs = 0;
    for (int k = 53; k <= 101; k++) begin
      @(negedge clk);
      npv += int'(bus.pix_valid);
      nfs += int'(bus.frame_start);
      if (k == 95) chk("drain busy at last cycle", 32'(bus.busy), 32'h1);
      if (k == 96) chk("drain busy after frame", 32'(bus.busy), 32'h0);
      if (k == 58) bus.en = 1'b0;
    end
    chk("drain remaining valid", 32'(npv), 32'd10);
    chk("drain no new frame", 32'(nfs), 32'd0);
    chk_vec("after drain", mk(0, 0, 0, 32'h0, 0, 24'h0, 1, 1, 0));

    // Asynchronous reset mid-line
    bus.en = 1'b1;
    for (int k = 0; k <= 4; k++) @(negedge clk);
    chk_vec("pre-reset", mk(4, 1, 1, 32'h100C, 1, 24'h001004, 1, 1, 0));
    #2 rst_n = 1'b0;
    #1;
    chk_vec("async reset", mk(0, 0, 0, 32'h0, 0, 24'h0, 1, 1, 0));
    chk("async reset rd_addr", bus.rd_addr, 32'h1000);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart after reset, with a short stop request that is cancelled mid-frame
    npv = 0; nidle = 0;
    for (int k = 0; k <= 52; k++) begin
      @(negedge clk);
      if (!bus.busy) nidle++;
      if (k >= 4 && k <= 50) npv += int'(bus.pix_valid);
      if (k == 1) chk_vec("restart k=1", mk(1, 1, 1, 32'h1000, 0, 24'h0, 1, 1, 0));
      if (k == 3) chk_vec("restart k=3", mk(3, 1, 1, 32'h1008, 1, 24'h001000, 1, 1, 1));
      if (k == 49) chk_vec("cancel k=49", mk(49, 1, 1, 32'h1000, 0, 24'h0, 0, 1, 0));
      if (k == 51) chk_vec("cancel k=51", mk(51, 1, 1, 32'h1008, 1, 24'h001000, 1, 1, 1));
      bus.en = !(k >= 20 && k < 23);
    end
    chk("cancel valid count", 32'(npv), 32'd11);
    chk("cancel busy gaps", 32'(nidle), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
